// File: rtl/sld_uart_loader.sv
// UART (8N1) scene-image loader writing an 8-bit distributed RAM with an async read port.
// Optional trailing checksum byte when SLD_LOADER_CHECKSUM_EN is defined.
//   state  | meaning
//   LEN_LO | waiting for length low byte
//   LEN_HI | waiting for length high byte
//   DATA   | writing data bytes to RAM
//   CSUM   | waiting for checksum byte (macro only)
//   DONE   | image loaded, terminal
//   ERR    | load failed, terminal
module sld_uart_loader #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH       = 1501
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [11:0] ra,
    output logic [7:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] count
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [11:0]   DEPTH_A  = 12'(DEPTH);
    localparam logic [15:0]   DEPTH_N  = 16'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [2:0] {
        LEN_LO, LEN_HI, DATA,
`ifdef SLD_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE, ERR
    } ld_t;

`ifdef SLD_LOADER_CHECKSUM_EN
    localparam ld_t FIN = CSUM;
`else
    localparam ld_t FIN = DONE;
`endif

    logic          s1_q, s2_q, s_prev_q;
    rx_t           rx_q, rx_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          vld_q, vld_d, ferr_q, ferr_d;
    ld_t           st_q, st_d;
    logic [15:0]   n_q, n_d;
    logic [11:0]   count_q, count_d;
    logic          we;
    logic [7:0]    mem_q [DEPTH] = '{default: 8'h00};
`ifdef SLD_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s_prev_q <= 1'b1;
            rx_q     <= RX_IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            vld_q    <= 1'b0;
            ferr_q   <= 1'b0;
            st_q     <= LEN_LO;
            n_q      <= '0;
            count_q  <= '0;
`ifdef SLD_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            s1_q     <= rxd;
            s2_q     <= s1_q;
            s_prev_q <= s2_q;
            rx_q     <= rx_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            vld_q    <= vld_d;
            ferr_q   <= ferr_d;
            st_q     <= st_d;
            n_q      <= n_d;
            count_q  <= count_d;
`ifdef SLD_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Timer is a down-counter; each phase acts when it reaches zero.
    always_comb begin
        rx_d   = rx_q;
        tmr_d  = tmr_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        vld_d  = 1'b0;
        ferr_d = 1'b0;
        if (rx_q != RX_IDLE) tmr_d = tmr_q - CW'(1);
        unique case (rx_q)
            RX_IDLE: if (s_prev_q && !s2_q) begin
                rx_d  = RX_START;
                tmr_d = HALF_BIT;
            end
            RX_START: if (tmr_q == '0) begin
                if (s2_q) begin
                    rx_d = RX_IDLE;
                end else begin
                    rx_d  = RX_DATA;
                    tmr_d = FULL_BIT;
                    bit_d = 3'd0;
                end
            end
            RX_DATA: if (tmr_q == '0) begin
                sh_d  = {s2_q, sh_q[7:1]};
                tmr_d = FULL_BIT;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) rx_d = RX_STOP;
            end
            RX_STOP: if (tmr_q == '0) begin
                vld_d  = s2_q;
                ferr_d = !s2_q;
                rx_d   = RX_IDLE;
            end
            default: rx_d = RX_IDLE;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        n_d     = n_q;
        count_d = count_q;
        we      = 1'b0;
`ifdef SLD_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (vld_q) csum_d = (st_q == LEN_LO) ? sh_q : csum_q + sh_q;
`endif
        case (st_q)
            LEN_LO:
                if (ferr_q) st_d = ERR;
                else if (vld_q) begin
                    n_d[7:0] = sh_q;
                    st_d     = LEN_HI;
                end
            LEN_HI:
                if (ferr_q) st_d = ERR;
                else if (vld_q) begin
                    n_d[15:8] = sh_q;
                    if ({sh_q, n_q[7:0]} > DEPTH_N) st_d = ERR;
                    else if ({sh_q, n_q[7:0]} == 16'd0) st_d = FIN;
                    else st_d = DATA;
                end
            DATA:
                if (ferr_q) st_d = ERR;
                else if (vld_q) begin
                    we      = 1'b1;
                    count_d = count_q + 12'd1;
                    if ({4'd0, count_d} == n_q) st_d = FIN;
                end
`ifdef SLD_LOADER_CHECKSUM_EN
            CSUM:
                if (ferr_q) st_d = ERR;
                else if (vld_q) st_d = (sh_q == csum_q) ? DONE : ERR;
`endif
            default: st_d = st_q;
        endcase
    end

    // RAM is deliberately outside reset so a failed or aborted load keeps prior bytes.
    always_ff @(posedge clk) begin
        if (we) mem_q[count_q[AW-1:0]] <= sh_q;
    end

    assign rd    = (ra < DEPTH_A) ? mem_q[ra[AW-1:0]] : 8'h00;
    assign count = count_q;
    assign done  = (st_q == DONE);
    assign err   = (st_q == ERR);
    assign busy  = (st_q == LEN_HI) || (st_q == DATA)
`ifdef SLD_LOADER_CHECKSUM_EN
                || (st_q == CSUM)
`endif
                || ((st_q == LEN_LO) && (rx_q != RX_IDLE));

endmodule

// File: tb/tb_sld_uart_loader.sv
// Randomized self-checking bench for sld_uart_loader against a byte-level load model.
module tb_sld_uart_loader;
    localparam int CPB   = 16;
    localparam int DEPTH = 1501;
`ifdef SLD_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [11:0] ra  = '0;
    logic [7:0]  rd;
    logic        busy, done, err;
    logic [11:0] count;

    int errs   = 0;
    int checks = 0;
    logic [7:0] ref_mem [DEPTH];

    sld_uart_loader #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .ra(ra), .rd(rd),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(CPB);
        end
        rxd = stop;
        cycles(CPB);
        rxd = 1'b1;
        cycles(4);
    endtask

    function automatic bq_t with_csum(input bq_t q);
        bq_t r;
        r = q;
`ifdef SLD_LOADER_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            foreach (q[i]) s = s + q[i];
            r.push_back(s);
        end
`endif
        return r;
    endfunction

    // Model: interpret the byte stream as length, payload, optional checksum.
    task automatic load(input string tag, input bq_t q, input int bad);
        int n, cnt;
        bit d, e;
        logic [7:0] sum;
        n = -1; cnt = 0; d = 0; e = 0; sum = 8'h00;
        foreach (q[i]) begin
            send_byte(q[i], i != bad);
            if (d || e) continue;
            if (i == bad) begin e = 1; continue; end
            if (i == 0) begin
                sum = q[i];
            end else if (i == 1) begin
                n = int'(q[1]) * 256 + int'(q[0]);
                sum = sum + q[i];
                if (n > DEPTH) e = 1;
                else if (n == 0) d = !CK;
            end else if (cnt < n) begin
                ref_mem[cnt] = q[i];
                cnt++;
                sum = sum + q[i];
                if (cnt == n) d = !CK;
            end else begin
                if (q[i] == sum) d = 1;
                else e = 1;
            end
        end
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".err"},   32'(err),   32'(e));
        chk({tag, ".busy"},  32'(busy),  32'(!d && !e && q.size() > 0));
    endtask

    task automatic check_mem(input string tag, input int upto);
        for (int a = 0; a < upto; a++) begin
            ra = 12'(a);
            #1 chk({tag, ".rd"}, 32'(rd), 32'(ref_mem[a]));
        end
        for (int k = 0; k < 3; k++) begin
            int a;
            a = int'($urandom_range(0, DEPTH - 1));
            ra = 12'(a);
            #1 chk({tag, ".rd_rand"}, 32'(rd), 32'(ref_mem[a]));
        end
        ra = 12'(DEPTH);
        #1 chk({tag, ".rd_oob"}, 32'(rd), 32'h00);
        ra = 12'hfff;
        #1 chk({tag, ".rd_max"}, 32'(rd), 32'h00);
    endtask

    initial begin
        bq_t q;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        cycles(3);
        chk("reset.busy",  32'(busy),  0);
        chk("reset.done",  32'(done),  0);
        chk("reset.err",   32'(err),   0);
        chk("reset.count", 32'(count), 0);
        rst = 1'b0;
        cycles(3);

        q = with_csum('{8'h03, 8'h00, 8'hAA, 8'h55, 8'h7E});
        load("load3", q, -1);
        check_mem("load3", 4);

        do_reset();
        q = '{8'h02, 8'h00, 8'h11, 8'h55, 8'h77};
        load("ferr", q, 3);
        check_mem("ferr", 2);

        do_reset();
        q = '{8'hDE, 8'h05};
        load("toolong", q, -1);

        // Glitch shorter than half a bit must not start a byte.
        do_reset();
        rxd = 1'b0;
        cycles(3);
        rxd = 1'b1;
        cycles(30);
        chk("glitch.busy",  32'(busy),  0);
        chk("glitch.count", 32'(count), 0);
        chk("glitch.err",   32'(err),   0);

        // Reset during the second data byte of a 4-byte load.
        q = '{8'h04, 8'h00, 8'hD0};
        load("midload", q, -1);
        rxd = 1'b0;
        cycles(3 * CPB);
        chk("midload.busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midload.busy_rst",  32'(busy),  0);
        chk("midload.count_rst", 32'(count), 0);
        chk("midload.done_rst",  32'(done),  0);
        rxd = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3);
        check_mem("midload", 2);
        q = with_csum('{8'h01, 8'h00, 8'h33});
        load("fresh", q, -1);
        check_mem("fresh", 2);

`ifdef SLD_LOADER_CHECKSUM_EN
        do_reset();
        q = '{8'h02, 8'h00, 8'h10, 8'h20, 8'h32};
        load("csum_ok", q, -1);
        do_reset();
        q = '{8'h02, 8'h00, 8'h10, 8'h20, 8'h33};
        load("csum_bad", q, -1);
        check_mem("csum_bad", 2);
`endif

        for (int it = 0; it < 8; it++) begin
            int n, kind, bad;
            do_reset();
            kind = int'($urandom_range(0, 4));
            q.delete();
            bad = -1;
            if (kind == 0) begin
                n = int'($urandom_range(DEPTH + 1, 4000));
                q.push_back(8'(n));
                q.push_back(8'(n >> 8));
                q.push_back(8'($urandom));
            end else begin
                n = int'($urandom_range(0, 10));
                q.push_back(8'(n));
                q.push_back(8'h00);
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                q = with_csum(q);
                if (kind == 1) bad = int'($urandom_range(0, q.size() - 1));
            end
            load("rand", q, bad);
            check_mem("rand", 12);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
